i2s_receiver: RTL and testbench

I2S slave receiver for the codec ADC path: the mirror image of the I2S transmit path. It samples externally driven bclk/lrclk/sdata, deserialises 24-bit left/right samples and presents complete stereo frames to the SoC with a valid/ack handshake. All logic runs in the clk_soc domain. The I2S inputs are treated as asynchronous and oversampled, so no second clock is needed.

---
 rtl/i2s_receiver.sv | 221 ++++++++++++++++++++++
 tb/tb_i2s_receiver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// I2S slave receiver for the codec ADC path. The bclk, lrclk and sdata inputs
// are oversampled in the clk_soc domain. Each half-frame is deserialised MSB
// first on falling bclk edges, and complete stereo frames are presented with a
// valid/ack handshake.
module i2s_receiver #(
  parameter int unsigned SAMPLE_BITS = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk_soc,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       bclk,
  input  logic                       lrclk,
  input  logic                       sdata,
  output logic [2*SAMPLE_BITS-1:0]   frame_out,
  output logic                       frame_valid,
  input  logic                       frame_ack,
  output logic                       frame_error,
  output logic                       overrun,
  input  logic                       clear_overrun
);

  localparam int unsigned CW = $clog2(SAMPLE_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLE_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SAMPLE_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  // synchroniser chains plus history flops for edge detection
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   bclk_hist_q, bclk_hist_d;
  logic                   lr_hist_q, lr_hist_d;

  // deserialiser state
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d;
  logic [SAMPLE_BITS-1:0] right_q, right_d;

  // frame FSM
  state_t                 state_q, state_d;
  logic                   bad_q, bad_d;
  logic                   commit_q, commit_d;
  logic                   good_q, good_d;

  // output registers
  logic [2*SAMPLE_BITS-1:0] frame_q, frame_d;
  logic                     valid_q, valid_d;
  logic                     error_q, error_d;
  logic                     overrun_q, overrun_d;

  logic bclk_fall;
  logic lr_fall;
  logic lr_rise;
  logic sd_bit;

  // shift each async input one stage deeper every clock
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], lrclk};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], sdata};
    bclk_hist_d = bclk_sync_q[SYNC_STAGES-1];
    lr_hist_d   = lr_sync_q[SYNC_STAGES-1];
  end

  // synchroniser and history registers
  always_ff @(posedge clk_soc) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_hist_q <= 1'b0;
      lr_hist_q   <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      bclk_hist_q <= bclk_hist_d;
      lr_hist_q   <= lr_hist_d;
    end
  end

  // edges seen where the last sync stage disagrees with its history flop
  always_comb begin
    bclk_fall = !bclk_sync_q[SYNC_STAGES-1] && bclk_hist_q;
    lr_fall   = !lr_sync_q[SYNC_STAGES-1] && lr_hist_q;
    lr_rise   = lr_sync_q[SYNC_STAGES-1] && !lr_hist_q;
    sd_bit    = sd_sync_q[SYNC_STAGES-1];
  end

  // bit counter and channel shift registers
  always_comb begin
    cnt_d   = cnt_q;
    left_d  = left_q;
    right_d = right_q;
    if (lr_fall || lr_rise) begin
      cnt_d = '0;
    end else if (bclk_fall) begin
      if (cnt_q < CNT_FULL) begin
        if (state_q == LEFT) begin
          left_d = {left_q[SAMPLE_BITS-2:0], sd_bit};
        end else if (state_q == RIGHT) begin
          right_d = {right_q[SAMPLE_BITS-2:0], sd_bit};
        end
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // deserialiser registers
  always_ff @(posedge clk_soc) begin
    if (reset) begin
      cnt_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // frame FSM: track halves, flag bad bit counts, raise commit at frame end
  always_comb begin
    state_d  = state_q;
    bad_d    = bad_q;
    commit_d = 1'b0;
    good_d   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (lr_fall) begin
            state_d = LEFT;
            bad_d   = 1'b0;
          end
        end
        LEFT: begin
          if (lr_rise) begin
            state_d = RIGHT;
            if (cnt_q != CNT_FULL) bad_d = 1'b1;
          end
        end
        RIGHT: begin
          if (lr_fall) begin
            state_d  = LEFT;
            commit_d = 1'b1;
            good_d   = !bad_q && (cnt_q == CNT_FULL);
            bad_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM registers
  always_ff @(posedge clk_soc) begin
    if (reset) begin
      state_q  <= IDLE;
      bad_q    <= 1'b0;
      commit_q <= 1'b0;
      good_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bad_q    <= bad_d;
      commit_q <= commit_d;
      good_q   <= good_d;
    end
  end

  // handshake, error pulse and overrun; left/right are still intact one cycle
  // after commit because bclk edges are several clk_soc cycles apart
  always_comb begin
    frame_d   = frame_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    error_d   = 1'b0;
    if (frame_ack && valid_q) valid_d = 1'b0;
    if (clear_overrun) overrun_d = 1'b0;
    if (commit_q) begin
      if (!good_q) begin
        error_d = 1'b1;
      end else if (!valid_q || frame_ack) begin
        frame_d = {left_q, right_q};
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // output registers
  always_ff @(posedge clk_soc) begin
    if (reset) begin
      frame_q   <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: a BFM drives I2S half-frames and the
// outputs are compared against hand-computed frames and flag values.
`timescale 1ns/1ps
module tb_i2s_receiver;

  localparam real CLK_HALF  = 4.1665;
  localparam real BCLK_HALF = 162.76;

  logic        clk_soc;
  logic        reset;
  logic        enable;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic [47:0] frame_out;
  logic        frame_valid;
  logic        frame_ack;
  logic        frame_error;
  logic        overrun;
  logic        clear_overrun;

  int tests_run;
  int tests_failed;
  int err_cnt;

  i2s_receiver #(
    .SAMPLE_BITS(24),
    .SYNC_STAGES(2)
  ) dut (
    .clk_soc(clk_soc),
    .reset(reset),
    .enable(enable),
    .bclk(bclk),
    .lrclk(lrclk),
    .sdata(sdata),
    .frame_out(frame_out),
    .frame_valid(frame_valid),
    .frame_ack(frame_ack),
    .frame_error(frame_error),
    .overrun(overrun),
    .clear_overrun(clear_overrun)
  );

  initial clk_soc = 1'b0;
  always #(CLK_HALF) clk_soc = ~clk_soc;

  // count frame_error cycles; each bad frame should add exactly one
  initial err_cnt = 0;
  always @(negedge clk_soc) if (frame_error === 1'b1) err_cnt++;

  task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_soc);
  endtask

  // one half-frame: lrclk and data change on bclk rise, sampled on bclk fall
  task automatic send_half(input logic lr, input logic [23:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bclk = 1'b1;
      if (i == 0) lrclk = lr;
      sdata = (i < 24) ? data[23-i] : 1'b0;
      #(BCLK_HALF);
      bclk = 1'b0;
      #(BCLK_HALF);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_half(1'b0, l, 24);
    send_half(1'b1, r, 24);
  endtask

  // lrclk fall with bclk idle: commits the frame, next LEFT starts at count 0
  task automatic close_frame();
    @(negedge clk_soc);
    lrclk = 1'b0;
    wait_clks(8);
  endtask

  task automatic pulse_ack();
    @(negedge clk_soc);
    frame_ack = 1'b1;
    @(negedge clk_soc);
    frame_ack = 1'b0;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    enable        = 1'b0;
    bclk          = 1'b0;
    lrclk         = 1'b1;
    sdata         = 1'b0;
    frame_ack     = 1'b0;
    clear_overrun = 1'b0;
    wait_clks(5);

    check_eq("rst_frame_out", frame_out, 48'h0);
    check_eq("rst_valid", {47'h0, frame_valid}, 48'h0);
    check_eq("rst_error", {47'h0, frame_error}, 48'h0);
    check_eq("rst_overrun", {47'h0, overrun}, 48'h0);

    reset  = 1'b0;
    enable = 1'b1;
    wait_clks(10);

    // 1: two good frames with latency check on the first commit
    send_frame(24'h123456, 24'habcdef);
    @(negedge clk_soc);
    lrclk = 1'b0;
    wait_clks(3);
    check_eq("t1_valid_early", {47'h0, frame_valid}, 48'h0);
    wait_clks(1);
    check_eq("t1_valid_lat", {47'h0, frame_valid}, 48'h1);
    check_eq("t1_frame_a", frame_out, 48'h123456abcdef);
    pulse_ack();
    check_eq("t1_ack_clears", {47'h0, frame_valid}, 48'h0);
    send_frame(24'h111111, 24'h222222);
    close_frame();
    check_eq("t1_frame_b", frame_out, 48'h111111222222);
    check_eq("t1_valid_b", {47'h0, frame_valid}, 48'h1);
    check_eq("t1_no_err", 48'(err_cnt), 48'h0);
    pulse_ack();

    // 2: reset asserted during a frame, released mid right half
    @(negedge clk_soc);
    reset = 1'b1;
    send_half(1'b1, 24'h777777, 10);
    @(negedge clk_soc);
    reset = 1'b0;
    send_half(1'b1, 24'h777777 << 10, 14);
    check_eq("t2_no_valid", {47'h0, frame_valid}, 48'h0);
    check_eq("t2_frame_zero", frame_out, 48'h0);
    send_frame(24'h333333, 24'h444444);
    close_frame();
    check_eq("t2_first_frame", frame_out, 48'h333333444444);
    check_eq("t2_valid", {47'h0, frame_valid}, 48'h1);
    check_eq("t2_no_err", 48'(err_cnt), 48'h0);
    pulse_ack();

    // 3: short left half (23 bits) then a good frame
    send_half(1'b0, 24'h999999, 23);
    send_half(1'b1, 24'haaaaaa, 24);
    send_frame(24'h555555, 24'h666666);
    close_frame();
    check_eq("t3_one_err", 48'(err_cnt), 48'h1);
    check_eq("t3_frame", frame_out, 48'h555555666666);
    check_eq("t3_valid", {47'h0, frame_valid}, 48'h1);
    check_eq("t3_no_overrun", {47'h0, overrun}, 48'h0);
    pulse_ack();

    // 4: long right half (26 bits) is discarded
    send_half(1'b0, 24'h121212, 24);
    send_half(1'b1, 24'h343434, 26);
    close_frame();
    check_eq("t4_err", 48'(err_cnt), 48'h2);
    check_eq("t4_no_valid", {47'h0, frame_valid}, 48'h0);
    check_eq("t4_frame_kept", frame_out, 48'h555555666666);

    // 5: three frames without ack
    send_frame(24'h0a0a0a, 24'h0b0b0b);
    send_half(1'b0, 24'h0c0c0c, 24);
    check_eq("t5_first_loaded", frame_out, 48'h0a0a0a0b0b0b);
    check_eq("t5_no_overrun_yet", {47'h0, overrun}, 48'h0);
    send_half(1'b1, 24'h0d0d0d, 24);
    send_frame(24'h0e0e0e, 24'h0f0f0f);
    close_frame();
    check_eq("t5_overrun", {47'h0, overrun}, 48'h1);
    check_eq("t5_frame_held", frame_out, 48'h0a0a0a0b0b0b);
    check_eq("t5_valid_held", {47'h0, frame_valid}, 48'h1);
    @(negedge clk_soc);
    clear_overrun = 1'b1;
    @(negedge clk_soc);
    clear_overrun = 1'b0;
    check_eq("t5_overrun_cleared", {47'h0, overrun}, 48'h0);
    pulse_ack();
    check_eq("t5_valid_cleared", {47'h0, frame_valid}, 48'h0);

    // 6: ack on the commit cycle, then enable drop mid-frame
    send_frame(24'hb1b1b1, 24'hb2b2b2);
    close_frame();
    check_eq("t6_b1", frame_out, 48'hb1b1b1b2b2b2);
    send_frame(24'hc1c1c1, 24'hc2c2c2);
    @(negedge clk_soc);
    lrclk = 1'b0;
    wait_clks(3);
    frame_ack = 1'b1;
    @(negedge clk_soc);
    frame_ack = 1'b0;
    wait_clks(2);
    check_eq("t6_ack_commit_frame", frame_out, 48'hc1c1c1c2c2c2);
    check_eq("t6_ack_commit_valid", {47'h0, frame_valid}, 48'h1);
    check_eq("t6_ack_commit_ovr", {47'h0, overrun}, 48'h0);

    send_half(1'b0, 24'h0f0f0f, 12);
    @(negedge clk_soc);
    enable = 1'b0;
    send_half(1'b0, 24'h0f0f0f << 12, 12);
    send_half(1'b1, 24'hf0f0f0, 24);
    close_frame();
    check_eq("t6_dis_no_err", 48'(err_cnt), 48'h2);
    check_eq("t6_dis_frame", frame_out, 48'hc1c1c1c2c2c2);
    check_eq("t6_dis_valid", {47'h0, frame_valid}, 48'h1);

    lrclk = 1'b1;
    wait_clks(8);
    enable = 1'b1;
    pulse_ack();
    send_frame(24'hdeadbe, 24'hef0123);
    close_frame();
    check_eq("t6_reenable_frame", frame_out, 48'hdeadbeef0123);
    check_eq("t6_reenable_valid", {47'h0, frame_valid}, 48'h1);
    check_eq("t6_final_err", 48'(err_cnt), 48'h2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
